// File: rtl/btn_debounce_pkg.sv
// Shared constants for the button conditioning path: clock rate, default timing, pin polarity.
package btn_debounce_pkg;

    localparam int   CLK_HZ              = 50_000_000;
    localparam int   DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;  // 20 ms
    localparam int   LONG_CYCLES_DEF     = CLK_HZ;       // 1 s
    localparam int   CNT_W_DEF           = 20;
    localparam int   HOLD_W_DEF          = 26;
    localparam logic BTN_PRESSED         = 1'b0;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous pins; output lags the pin by two clk edges.
// Reset value is parameterised so an idle pin does not look active coming out of reset.
module btn_debounce_sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= {WIDTH{RST_VAL}};
            s2_q <= {WIDTH{RST_VAL}};
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces an active-low raw button into a level, press/release/long-press pulses and a direction toggle.
// Latency: pin change to pressed_o is 2 + DEBOUNCE_CYCLES edges; outputs are fire-and-forget pulses.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int HOLD_W          = HOLD_W_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_n_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic dir_o
);

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic btn_n_s;

    btn_debounce_sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (btn_n_i),
        .q_o     (btn_n_s)
    );

    logic              db_n_q, db_n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              dir_q, dir_d;
    logic              flip, fall, rise;

    always_comb begin
        flip      = (btn_n_s != db_n_q) && (cnt_q == DB_LAST);
        fall      = flip && (db_n_q != BTN_PRESSED);
        rise      = flip && (db_n_q == BTN_PRESSED);
        db_n_d    = flip ? btn_n_s : db_n_q;
        press_d   = fall;
        release_d = rise;
        dir_d     = dir_q ^ fall;

        // Any return to the settled level restarts qualification.
        if ((btn_n_s == db_n_q) || flip) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A release landing on the completing cycle suppresses long_press.
        hold_d = hold_q;
        long_d = 1'b0;
        if ((db_n_q != BTN_PRESSED) || rise) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            db_n_q    <= 1'b1;
            cnt_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            db_n_q    <= db_n_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            dir_q     <= dir_d;
        end
    end

    assign pressed_o    = (db_n_q == BTN_PRESSED);
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign dir_o        = dir_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
module tb_btn_debounce;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic btn_n_i;
    logic pressed_o, press_o, release_o, long_press_o, dir_o;

    btn_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16),
        .CNT_W           (3),
        .HOLD_W          (5)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .btn_n_i      (btn_n_i),
        .pressed_o    (pressed_o),
        .press_o      (press_o),
        .release_o    (release_o),
        .long_press_o (long_press_o),
        .dir_o        (dir_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic btn;
        int   cycles;
        int   n_press;
        int   n_rel;
        int   n_long;
        logic pressed_end;
        logic dir_end;
    } seg_t;

    seg_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [4:0] outs();
        return {pressed_o, press_o, release_o, long_press_o, dir_o};
    endfunction

    task automatic check(input string name, input int idx, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: {pressed,press,release,long,dir} got %b, want %b", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    // Inputs change on the falling edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        int np, nr, nl, both;

        // Bounce: 12 cycles of 2-cycle toggling, then settle low.
        for (int i = 0; i < 6; i++) tbl.push_back('{btn: i[0], cycles: 2, n_press: 0, n_rel: 0, n_long: 0, pressed_end: 1'b0, dir_end: 1'b1});
        tbl.push_back('{1'b0, 6, 1, 0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 10, 0, 1, 0, 1'b0, 1'b0});
        // Short glitch: three low cycles never qualify.
        tbl.push_back('{1'b0, 3, 0, 0, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 10, 0, 0, 0, 1'b0, 1'b0});
        // Two qualified presses.
        tbl.push_back('{1'b0, 8, 1, 0, 0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 10, 0, 1, 0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8, 1, 0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 10, 0, 1, 0, 1'b0, 1'b0});

        rst_n_i = 1'b0;
        btn_n_i = 1'b1;
        repeat (3) tick();
        check("reset", 0, outs(), 5'b00000);
        rst_n_i = 1'b1;
        repeat (5) tick();
        check("idle", 0, outs(), 5'b00000);

        // Clean press held 30 cycles.
        btn_n_i = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            check("clean_hold", k, outs(), {k >= 6, k == 6, 1'b0, k == 22, k >= 6});
        end
        btn_n_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("clean_rel", k, outs(), {k < 6, 1'b0, k == 6, 1'b0, 1'b1});
        end

        both = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            btn_n_i = tbl[i].btn;
            np = 0;
            nr = 0;
            nl = 0;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                tick();
                np += int'(press_o);
                nr += int'(release_o);
                nl += int'(long_press_o);
                if (press_o && release_o) both++;
            end
            check_int("seg_press", i, np, tbl[i].n_press);
            check_int("seg_release", i, nr, tbl[i].n_rel);
            check_int("seg_long", i, nl, tbl[i].n_long);
            check_int("seg_level_dir", i, int'({pressed_o, dir_o}), int'({tbl[i].pressed_end, tbl[i].dir_end}));
        end
        check_int("press_and_release_together", 0, both, 0);

        // Reset mid-hold at hold count 10, button still held.
        btn_n_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("rst_pre", k, outs(), {k >= 6, k == 6, 1'b0, 1'b0, k >= 6});
        end
        rst_n_i = 1'b0;
        #1;
        check("rst_async", 0, outs(), 5'b00000);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("rst_held", k, outs(), 5'b00000);
        end
        rst_n_i = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("rst_post", k, outs(), {k >= 6, k == 6, 1'b0, k == 22, k >= 6});
        end
        btn_n_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("rst_rel", k, outs(), {k < 6, 1'b0, k == 6, 1'b0, 1'b1});
        end

        // Release landing exactly where the hold count would reach 16.
        btn_n_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("bnd_hold", k, outs(), {k >= 6, k == 6, 1'b0, 1'b0, k < 6});
        end
        btn_n_i = 1'b1;
        for (int k = 17; k <= 30; k++) begin
            tick();
            check("bnd_rel", k, outs(), {k < 22, 1'b0, k == 22, 1'b0, 1'b0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
